// File: rtl/decodificador_resultado_pkg.sv
// decodificador_resultado_pkg: shared FSM encoding and BCD digit width
package decodificador_resultado_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  localparam int DIGIT_W = 4;
endpackage

// File: rtl/decodificador_resultado_if.sv
// decodificador_resultado_if: request/result bundle between ALU register and display decoder
interface decodificador_resultado_if #(
  parameter int WIDTH = 4,
  parameter int DIGITS = 2
);
  logic start;
  logic [WIDTH-1:0] S;
  logic Bout;
  logic busy;
  logic done;
  logic sign;
  logic [4*DIGITS-1:0] bcd;
  modport master(output start, S, Bout, input busy, done, sign, bcd);
  modport slave(input start, S, Bout, output busy, done, sign, bcd);
endinterface

// File: rtl/decodificador_resultado_corretor_add3.sv
// corretor_add3: double-dabble digit correction, adds 3 to digits of 5 or more
module corretor_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/decodificador_resultado.sv
// decodificador_resultado: two's-complement subtractor result to sign + BCD magnitude
module decodificador_resultado
  import decodificador_resultado_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIGITS = 2
) (
  input logic clk,
  input logic reset,
  decodificador_resultado_if.slave bus
);
  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 2);
  state_t state, nextState;
  logic [WIDTH-1:0] latS;
  logic latBout;
  logic [BCD_W+WIDTH:0] shiftReg;
  logic [BCD_W+WIDTH:0] shifted;
  logic [BCD_W-1:0] corrected;
  logic [WIDTH:0] mag;
  logic [CNT_W-1:0] count;
  logic lastShift;
  logic signReg;
  logic [BCD_W-1:0] bcdReg;
  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    corretor_add3 u_add3 (
      .d(shiftReg[WIDTH+1+DIGIT_W*i +: DIGIT_W]),
      .q(corrected[DIGIT_W*i +: DIGIT_W])
    );
  end
  // magnitude is one bit wider so Bout=1,S=0 decodes as -2^WIDTH
  assign mag = latBout ? {1'b1, {WIDTH{1'b0}}} - {1'b0, latS} : {1'b0, latS};
  assign shifted = {corrected[BCD_W-2:0], shiftReg[WIDTH:0], 1'b0};
  assign lastShift = count == CNT_W'(WIDTH);
  assign bus.sign = signReg;
  assign bus.bcd = bcdReg;
  always_comb begin
    nextState = state;
    nextState = state == ST_IDLE ? (bus.start ? ST_LOAD : ST_IDLE) :
                state == ST_LOAD ? ST_SHIFT :
                state == ST_SHIFT ? (lastShift ? ST_DONE : ST_SHIFT) : ST_IDLE;
    bus.busy = state != ST_IDLE;
    bus.done = state == ST_DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else state <= nextState;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      latS <= '0;
      latBout <= 1'b0;
      shiftReg <= '0;
      count <= '0;
      signReg <= 1'b0;
      bcdReg <= '0;
    end else if (state == ST_IDLE && bus.start) begin
      latS <= bus.S;
      latBout <= bus.Bout;
    end else if (state == ST_LOAD) begin
      shiftReg <= {{BCD_W{1'b0}}, mag};
      count <= '0;
    end else if (state == ST_SHIFT) begin
      shiftReg <= shifted;
      count <= count + 1'b1;
      if (lastShift) begin
        signReg <= latBout;
        bcdReg <= shifted[BCD_W+WIDTH:WIDTH+1];
      end
    end
  end
endmodule
